// File: rtl/lenet_pkg.sv
// ---------------------------------------------------------------------------
// lenet_pkg
// Shared definitions for the LeNet datapath slice:
//   - the conv layer 2 input feature-map dimensions and default word width,
//   - the loader state type,
//   - a helper that sizes an index counter for a given extent.
// ---------------------------------------------------------------------------
package lenet_pkg;

    localparam int C2_IN_CH   = 2;
    localparam int C2_IN_ROWS = 14;
    localparam int C2_IN_COLS = 14;
    localparam int BITWIDTH   = 16;

    // FILL: accepting pixels into the array.
    // FULL: array holds a complete frame and waits for frame_ack.
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } load_state_t;

    // Index width for a dimension of n entries; never narrower than 1 bit so
    // a dimension of 1 still gets a legal counter.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fmap_stream_loader_if.sv
// ---------------------------------------------------------------------------
// fmap_stream_loader_if
// Bundles the pixel stream input and the frame output of the loader.
//
// Stream side (valid/ready): a beat transfers on a rising clock edge where
// in_valid and in_ready are both high. The producer holds in_data and
// in_last stable while in_valid is high and in_ready is low; in_ready never
// depends combinationally on in_valid.
//
// Frame side: featuremap1 is meaningful while frame_valid is high and stays
// stable until frame_ack is seen high on a rising edge. frame_error is a
// single-cycle pulse reporting a framing mismatch.
//
// Modports:
//   master - producer/consumer side (drives in_*, frame_ack)
//   slave  - the loader (drives in_ready, featuremap1, frame_valid,
//            frame_error)
// ---------------------------------------------------------------------------
interface fmap_stream_loader_if
    import lenet_pkg::*;
#(
    parameter int bitwidth = BITWIDTH,
    parameter int CHANNELS = C2_IN_CH,
    parameter int ROWS     = C2_IN_ROWS,
    parameter int COLS     = C2_IN_COLS
);

    logic                        in_valid;
    logic                        in_ready;
    logic signed [bitwidth-1:0]  in_data;
    logic                        in_last;

    logic signed [CHANNELS-1:0][ROWS-1:0][COLS-1:0][bitwidth-1:0] featuremap1;
    logic                        frame_valid;
    logic                        frame_ack;
    logic                        frame_error;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output frame_ack,
        input  in_ready,
        input  featuremap1,
        input  frame_valid,
        input  frame_error
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  frame_ack,
        output in_ready,
        output featuremap1,
        output frame_valid,
        output frame_error
    );

endinterface

// File: rtl/fmap_stream_loader_raster.sv
// ---------------------------------------------------------------------------
// fmap_raster_counter
// Nested channel/row/column counter walking a feature map in channel-major
// raster order (col fastest, then row, then ch).
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   advance    - step to the next raster position
//   clear      - return to position [0][0][0]; wins over advance
//   ch/row/col - current position
//   at_final   - current position is the last cell of the map
// ---------------------------------------------------------------------------
module fmap_raster_counter
    import lenet_pkg::*;
#(
    parameter int CHANNELS = C2_IN_CH,
    parameter int ROWS     = C2_IN_ROWS,
    parameter int COLS     = C2_IN_COLS,
    localparam int CW      = idx_width(CHANNELS),
    localparam int RW      = idx_width(ROWS),
    localparam int LW      = idx_width(COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    input  logic          clear,
    output logic [CW-1:0] ch,
    output logic [RW-1:0] row,
    output logic [LW-1:0] col,
    output logic          at_final
);

    logic col_wrap;
    logic row_wrap;
    logic ch_wrap;

    assign col_wrap = (col == LW'(COLS - 1));
    assign row_wrap = (row == RW'(ROWS - 1));
    assign ch_wrap  = (ch  == CW'(CHANNELS - 1));
    assign at_final = col_wrap && row_wrap && ch_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch  <= '0;
            row <= '0;
            col <= '0;
        end else if (clear) begin
            ch  <= '0;
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col_wrap) begin
                col <= '0;
                if (row_wrap) begin
                    row <= '0;
                    ch  <= ch_wrap ? '0 : ch + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fmap_stream_loader.sv
// ---------------------------------------------------------------------------
// fmap_stream_loader
// Assembles the conv layer 2 input feature map from a serial signed pixel
// stream (channel-major raster order) into a registered [ch][row][col]
// array, then presents it to the conv layer 2 datapath and holds it until
// acknowledged.
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - fmap_stream_loader_if.slave: pixel stream in, frame out
//   state_dbg  - current FSM state (observation only)
//
// A frame completes only when in_last coincides with the final raster
// position. Any mismatch (in_last early, or missing at the final position)
// pulses frame_error, rewinds the counters and discards the frame; cells it
// wrote keep their values but are never presented as valid.
// ---------------------------------------------------------------------------
module fmap_stream_loader
    import lenet_pkg::*;
#(
    parameter int bitwidth = BITWIDTH,
    parameter int CHANNELS = C2_IN_CH,
    parameter int ROWS     = C2_IN_ROWS,
    parameter int COLS     = C2_IN_COLS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fmap_stream_loader_if.slave  bus,
    output load_state_t          state_dbg
);

    localparam int CW = idx_width(CHANNELS);
    localparam int RW = idx_width(ROWS);
    localparam int LW = idx_width(COLS);

    load_state_t state_q;
    load_state_t state_d;

    logic [CW-1:0] ch;
    logic [RW-1:0] row;
    logic [LW-1:0] col;
    logic          at_final;

    logic accept;
    logic advance;
    logic clear;
    logic error_d;
    logic error_q;

    logic signed [CHANNELS-1:0][ROWS-1:0][COLS-1:0][bitwidth-1:0] fm_q;

    fmap_raster_counter #(
        .CHANNELS (CHANNELS),
        .ROWS     (ROWS),
        .COLS     (COLS)
    ) u_raster (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (advance),
        .clear    (clear),
        .ch       (ch),
        .row      (row),
        .col      (col),
        .at_final (at_final)
    );

    // Handshake outputs decode from the registered state only.
    assign bus.in_ready    = (state_q == FILL);
    assign bus.frame_valid = (state_q == FULL);
    assign bus.frame_error = error_q;
    assign bus.featuremap1 = fm_q;
    assign state_dbg       = state_q;

    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        clear   = 1'b0;
        error_d = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    advance = 1'b1;
                    // in_last and the final position must agree; either one
                    // alone ends the (bad) frame and rewinds the counters.
                    if (bus.in_last || at_final) begin
                        clear = 1'b1;
                        if (bus.in_last && at_final) begin
                            state_d = FULL;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
            end
            FULL: begin
                if (bus.frame_ack) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Cells change only on accepted beats, so the array is frozen in FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fm_q <= '0;
        end else if (accept) begin
            fm_q[ch][row][col] <= bus.in_data;
        end
    end

endmodule
